// File: rtl/bcd_round_judge.sv
// Round judge for the card game: waits for every player, judges each Slave
// against the Master one per clock, converts the Master total to BCD and keeps per-Slave win tallies.
module bcd_round_judge #(
    parameter int NUM_SLAVES = 2,
    parameter int VALUE_W    = 5,
    parameter int BUST_LIMIT = 21,
    parameter int WINS_W     = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           roundStart,
    input  logic                           clearTally,
    input  logic [NUM_SLAVES-1:0]          finishSlave,
    input  logic                           finishMaster,
    input  logic [NUM_SLAVES*VALUE_W-1:0]  totalValueSlave,
    input  logic [VALUE_W-1:0]             totalValueMaster,
    output logic                           resultValid,
    output logic [2*NUM_SLAVES-1:0]        SlaveState,
    output logic [1:0]                     MasterState,
    output logic [3:0]                     ScoreTen,
    output logic [3:0]                     ScoreOne,
    output logic [NUM_SLAVES*WINS_W-1:0]   SlaveWins
);
    localparam int                IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [IDX_W-1:0]  LAST_K   = IDX_W'(NUM_SLAVES - 1);
    localparam logic [VALUE_W:0]  BUST_L   = (VALUE_W + 1)'(BUST_LIMIT);
    localparam logic [WINS_W-1:0] WINS_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_JUDGE,
        S_BCD,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   k_q;
    logic [VALUE_W-1:0] slave_tot_q [NUM_SLAVES];
    logic [VALUE_W-1:0] master_tot_q;
    logic [6:0]         w_q;
    logic [3:0]         tens_q;
    logic [3:0]         nwin_q;
    logic [3:0]         nlose_q;
    logic               valid_q;
    logic [1:0]         slave_state_q [NUM_SLAVES];
    logic [1:0]         master_state_q;
    logic [3:0]         ten_q;
    logic [3:0]         one_q;
    logic [WINS_W-1:0]  wins_q [NUM_SLAVES];

    logic [1:0]         res_d;
    logic [3:0]         nwin_d;
    logic [3:0]         nlose_d;

    // Bust is checked one bit wider than the totals so BUST_LIMIT never wraps.
    function automatic logic [1:0] judge(input logic [VALUE_W-1:0] s,
                                         input logic [VALUE_W-1:0] m);
        if ({1'b0, s} > BUST_L)      return 2'b10;
        else if ({1'b0, m} > BUST_L) return 2'b01;
        else if (s > m)              return 2'b01;
        else if (s < m)              return 2'b10;
        else                         return 2'b11;
    endfunction

    function automatic logic [WINS_W-1:0] sat_inc(input logic [WINS_W-1:0] c);
        return (c == WINS_MAX) ? c : c + WINS_W'(1);
    endfunction

    function automatic logic [6:0] clamp99(input logic [VALUE_W-1:0] m);
        logic [6:0] mx;
        mx = 7'(m);
        return (mx > 7'd99) ? 7'd99 : mx;
    endfunction

    always_comb begin
        res_d   = judge(slave_tot_q[k_q], master_tot_q);
        nwin_d  = nwin_q + 4'(res_d == 2'b01);
        nlose_d = nlose_q + 4'(res_d == 2'b10);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            k_q            <= '0;
            master_tot_q   <= '0;
            w_q            <= '0;
            tens_q         <= '0;
            nwin_q         <= '0;
            nlose_q        <= '0;
            valid_q        <= 1'b0;
            master_state_q <= '0;
            ten_q          <= '0;
            one_q          <= '0;
            for (int i = 0; i < NUM_SLAVES; i++) begin
                slave_tot_q[i]   <= '0;
                slave_state_q[i] <= '0;
                wins_q[i]        <= '0;
            end
        end else begin
            if (roundStart) begin
                // A new round aborts whatever is in flight; tallies are untouched.
                state_q        <= S_WAIT;
                valid_q        <= 1'b0;
                master_state_q <= '0;
                ten_q          <= '0;
                one_q          <= '0;
                for (int i = 0; i < NUM_SLAVES; i++) slave_state_q[i] <= '0;
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_WAIT: begin
                        if (finishMaster && (&finishSlave)) begin
                            for (int i = 0; i < NUM_SLAVES; i++)
                                slave_tot_q[i] <= totalValueSlave[i*VALUE_W +: VALUE_W];
                            master_tot_q <= totalValueMaster;
                            w_q          <= clamp99(totalValueMaster);
                            tens_q       <= '0;
                            k_q          <= '0;
                            nwin_q       <= '0;
                            nlose_q      <= '0;
                            state_q      <= S_JUDGE;
                        end
                    end
                    S_JUDGE: begin
                        slave_state_q[k_q] <= res_d;
                        nwin_q             <= nwin_d;
                        nlose_q            <= nlose_d;
                        if (k_q == LAST_K) begin
                            state_q <= S_BCD;
                            if (nlose_d > nwin_d)      master_state_q <= 2'b01;
                            else if (nlose_d < nwin_d) master_state_q <= 2'b10;
                            else                       master_state_q <= 2'b11;
                        end else begin
                            k_q <= k_q + IDX_W'(1);
                        end
                    end
                    S_BCD: begin
                        if (w_q >= 7'd10) begin
                            w_q    <= w_q - 7'd10;
                            tens_q <= tens_q + 4'd1;
                        end else begin
                            one_q   <= w_q[3:0];
                            ten_q   <= tens_q;
                            valid_q <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                    S_DONE: ;
                    default: state_q <= S_IDLE;
                endcase
            end

            // Clear has priority over a same-cycle win.
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (clearTally)
                    wins_q[i] <= '0;
                else if (!roundStart && state_q == S_JUDGE && k_q == IDX_W'(i) && res_d == 2'b01)
                    wins_q[i] <= sat_inc(wins_q[i]);
            end
        end
    end

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_pack
        assign SlaveState[2*i +: 2]          = slave_state_q[i];
        assign SlaveWins[i*WINS_W +: WINS_W] = wins_q[i];
    end

    assign resultValid = valid_q;
    assign MasterState = master_state_q;
    assign ScoreTen    = ten_q;
    assign ScoreOne    = one_q;

endmodule

// File: tb/tb_bcd_round_judge.sv
// Scoreboard bench for bcd_round_judge with two Slaves: the driver queues expected
// round results, a monitor checks them when resultValid rises.
module tb_bcd_round_judge;
    localparam int NS = 2;
    localparam int VW = 5;
    localparam int WW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              roundStart = 1'b0;
    logic              clearTally = 1'b0;
    logic [NS-1:0]     finishSlave = '0;
    logic              finishMaster = 1'b0;
    logic [NS*VW-1:0]  totalValueSlave = '0;
    logic [VW-1:0]     totalValueMaster = '0;
    logic              resultValid;
    logic [2*NS-1:0]   SlaveState;
    logic [1:0]        MasterState;
    logic [3:0]        ScoreTen;
    logic [3:0]        ScoreOne;
    logic [NS*WW-1:0]  SlaveWins;

    bcd_round_judge #(
        .NUM_SLAVES(NS),
        .VALUE_W(VW),
        .BUST_LIMIT(21),
        .WINS_W(WW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .roundStart(roundStart),
        .clearTally(clearTally),
        .finishSlave(finishSlave),
        .finishMaster(finishMaster),
        .totalValueSlave(totalValueSlave),
        .totalValueMaster(totalValueMaster),
        .resultValid(resultValid),
        .SlaveState(SlaveState),
        .MasterState(MasterState),
        .ScoreTen(ScoreTen),
        .ScoreOne(ScoreOne),
        .SlaveWins(SlaveWins)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int ss;
        int ms;
        int ten;
        int one;
        int wins;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   e0 = 0;
    bit   prev_v = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: one scoreboard entry per rising resultValid.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (resultValid && !prev_v) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("SlaveState",  int'(SlaveState),  e.ss);
                    chk("MasterState", int'(MasterState), e.ms);
                    chk("ScoreTen",    int'(ScoreTen),    e.ten);
                    chk("ScoreOne",    int'(ScoreOne),    e.one);
                    chk("SlaveWins",   int'(SlaveWins),   e.wins);
                    chk("latency",     cyc - e0,          e.lat);
                end
            end
            prev_v = resultValid;
        end
    end

    task automatic set_totals(input int s0, input int s1, input int m);
        totalValueSlave  = {VW'(s1), VW'(s0)};
        totalValueMaster = VW'(m);
    endtask

    task automatic begin_round();
        @(negedge clk); roundStart = 1'b1;
        @(negedge clk); roundStart = 1'b0;
    endtask

    // Everyone finishes now; the next edge latches. Totals are then scrambled.
    task automatic latch_now(input int s0, input int s1, input int m);
        set_totals(s0, s1, m);
        finishSlave  = '1;
        finishMaster = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        finishSlave  = '0;
        finishMaster = 1'b0;
        set_totals(31, 31, 31);
    endtask

    task automatic push(input int ss, input int ms, input int ten, input int one,
                        input int wins, input int lat);
        exp_t e;
        e.ss = ss; e.ms = ms; e.ten = ten; e.one = one; e.wins = wins; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic wait_result();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("result_timeout", 0, 1);
            sb.delete();
        end
    endtask

    task automatic round(input int s0, input int s1, input int m,
                         input int ss, input int ms, input int ten, input int one,
                         input int wins, input int lat, input bit clr_k0);
        push(ss, ms, ten, one, wins, lat);
        begin_round();
        latch_now(s0, s1, m);
        if (clr_k0) begin
            clearTally = 1'b1;
            @(negedge clk);
            clearTally = 1'b0;
        end
        wait_result();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid",  int'(resultValid), 0);
        chk("rst_slave",  int'(SlaveState),  0);
        chk("rst_master", int'(MasterState), 0);
        chk("rst_score",  int'({ScoreTen, ScoreOne}), 0);
        chk("rst_wins",   int'(SlaveWins),   0);
        rst_n = 1'b1;

        // Basic rounds: win/lose, bust cases, all pushes.
        round(19, 17, 18, 4'b1001, 2'b11, 1, 8, 8'h01, 4, 1'b0);
        round(23, 20, 22, 4'b0110, 2'b11, 2, 2, 8'h11, 5, 1'b0);
        round(20, 20, 20, 4'b1111, 2'b11, 2, 0, 8'h11, 5, 1'b0);

        // Staggered finishes; Slave0 total only becomes valid at cycle 9.
        push(4'b1001, 2'b11, 1, 7, 8'h12, 4);
        begin_round();
        set_totals(5, 15, 17);
        for (int c = 1; c <= 9; c++) begin
            if (c == 3) finishSlave[1] = 1'b1;
            if (c == 7) finishMaster = 1'b1;
            if (c == 9) begin
                set_totals(18, 15, 17);
                finishSlave[0] = 1'b1;
                e0 = cyc + 1;
            end
            @(negedge clk);
        end
        finishSlave  = '0;
        finishMaster = 1'b0;
        set_totals(31, 31, 31);
        wait_result();

        // Saturation of Slave0 tally.
        @(negedge clk); clearTally = 1'b1;
        @(negedge clk); clearTally = 1'b0;
        chk("clear_wins", int'(SlaveWins), 0);
        for (int i = 0; i < 16; i++)
            round(20, 10, 18, 4'b1001, 2'b11, 1, 8, (i + 1 > 15) ? 15 : i + 1, 4, 1'b0);
        // clearTally on Slave0's winning cycle; Slave1 wins the cycle after.
        round(20, 19, 18, 4'b0101, 2'b10, 1, 8, 8'h10, 4, 1'b1);

        // roundStart during JUDGE.
        begin_round();
        latch_now(10, 10, 19);
        @(negedge clk);
        chk("partial_judge", int'(SlaveState), 4'b0010);
        roundStart = 1'b1;
        @(negedge clk);
        roundStart = 1'b0;
        chk("abort_slave",  int'(SlaveState),  0);
        chk("abort_master", int'(MasterState), 0);
        chk("abort_valid",  int'(resultValid), 0);
        chk("abort_wins",   int'(SlaveWins),   8'h10);
        round(21, 22, 21, 4'b1011, 2'b01, 2, 1, 8'h10, 5, 1'b0);

        // Reset during BCD conversion.
        begin_round();
        latch_now(5, 6, 30);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_master", int'(MasterState), 2'b10);
        rst_n = 1'b0;
        @(negedge clk);
        chk("bcd_rst_valid",  int'(resultValid), 0);
        chk("bcd_rst_slave",  int'(SlaveState),  0);
        chk("bcd_rst_master", int'(MasterState), 0);
        chk("bcd_rst_score",  int'({ScoreTen, ScoreOne}), 0);
        chk("bcd_rst_wins",   int'(SlaveWins),   0);
        rst_n = 1'b1;
        round(17, 21, 16, 4'b0101, 2'b10, 1, 6, 8'h11, 4, 1'b0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
